// File: rtl/fp_conv_pkg.sv
// Shared constants and types for the 8-bit FP code {S, E[2:0], F[3:0]}
// and its 12-bit two's-complement linear form.
package fp_conv_pkg;

  localparam int FP_EXP_W = 3;
  localparam int FP_SIG_W = 4;
  localparam int LIN_W    = 12;
  localparam int MAG_W    = 11;

  localparam int FP_SIGN_POS = 7;
  localparam int FP_EXP_MSB  = 6;
  localparam int FP_EXP_LSB  = 4;
  localparam int FP_SIG_MSB  = 3;
  localparam int FP_SIG_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_decoder_if.sv
// Valid/ready bus between an FP code producer, the decoder and the
// consumer of the linear result.
interface fp_decoder_if;
  import fp_conv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_fp;
  logic             out_valid;
  logic             out_ready;
  logic [LIN_W-1:0] out_data;

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fp_dec_shifter.sv
// Magnitude/count registers for the one-bit-per-cycle left shift.
// FP_DECODER_MIDPOINT_EN: the first shift of an E>0 code brings in a 1.
module fp_dec_shifter
  import fp_conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift_en,
  input  logic [FP_EXP_W-1:0] exp_in,
  input  logic [FP_SIG_W-1:0] sig_in,
  output logic [MAG_W-1:0]    mag,
  output logic                done
);

  logic [MAG_W-1:0]    mag_reg;
  logic [FP_EXP_W-1:0] cnt_reg;
  logic [MAG_W-1:0]    shifted;
  logic                shift_in;

`ifdef FP_DECODER_MIDPOINT_EN
  // Shifting a 1 in first gives (F<<E) + (1<<(E-1)) with the same cycle count.
  logic first_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_reg <= 1'b0;
    end else if (load) begin
      first_reg <= (exp_in != '0);
    end else if (shift_en && cnt_reg != '0) begin
      first_reg <= 1'b0;
    end
  end

  assign shift_in = first_reg;
`else
  assign shift_in = 1'b0;
`endif

  assign shifted[0] = shift_in;
  for (genvar gi = 1; gi < MAG_W; gi++) begin : g_shl
    assign shifted[gi] = mag_reg[gi-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      mag_reg <= {{(MAG_W-FP_SIG_W){1'b0}}, sig_in};
      cnt_reg <= exp_in;
    end else if (shift_en && cnt_reg != '0) begin
      mag_reg <= shifted;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign mag  = mag_reg;
  assign done = (cnt_reg == '0);

endmodule

// File: rtl/fp_decoder.sv
// Iterative FP-code to 12-bit two's-complement decoder with valid/ready on
// both sides. Build option FP_DECODER_MIDPOINT_EN selects midpoint rebuild.
module fp_decoder
  import fp_conv_pkg::*;
(
  input logic         clk,
  input logic         rst,
  fp_decoder_if.slave bus
);

  state_t           state_reg, state_next;
  logic             sign_reg;
  logic [LIN_W-1:0] out_data_reg;
  logic             load;
  logic             shift_en;
  logic [MAG_W-1:0] mag;
  logic             done;
  logic [LIN_W-1:0] mag_ext;

  fp_dec_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .exp_in   (bus.in_fp[FP_EXP_MSB:FP_EXP_LSB]),
    .sig_in   (bus.in_fp[FP_SIG_MSB:FP_SIG_LSB]),
    .mag      (mag),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift_en   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mag_ext = {1'b0, mag};

  // Result register only moves on SHIFT->DONE; it holds across IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg     <= 1'b0;
      out_data_reg <= '0;
    end else begin
      if (load) begin
        sign_reg <= bus.in_fp[FP_SIGN_POS];
      end
      if (state_reg == SHIFT && done) begin
        out_data_reg <= sign_reg ? -mag_ext : mag_ext;
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_fp_decoder.sv
// Directed self-checking bench for fp_decoder: values, latency,
// backpressure, reset mid-shift and back-to-back throughput.
module tb_fp_decoder;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;

  fp_decoder_if bus ();

  fp_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: wait for in_ready, present code, count latency, consume.
  task automatic decode(input logic [7:0] code, input logic [11:0] want);
    int          lat;
    int          guard;
    logic [7:0]  c;
    logic [2:0]  e;
    c = code;
    e = c[6:4];
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      step();
      guard++;
    end
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_fp    = c;
    step();
    bus.in_valid = 1'b0;
    bus.in_fp    = 8'h5A;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", lat, 32'(e) + 1);
    check("out_data", bus.out_data, want);
    $display("decode %02h -> %03h (want %03h) latency %0d", c, bus.out_data, want, lat);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("out_valid_after_accept", bus.out_valid, 1'b0);
    check("in_ready_after_accept", bus.in_ready, 1'b1);
    check("out_data_hold_idle", bus.out_data, want);
  endtask

  logic [7:0]  b2b_code [3];
  logic [11:0] b2b_want [3];

  initial begin
    int k;
    int r;
    int last_t;
    logic was_ready;
    total_cnt = 0;
    pass_cnt  = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_fp     = 8'h00;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_data", bus.out_data, 12'h000);

`ifdef FP_DECODER_MIDPOINT_EN
    decode(8'h1B, 12'h017);
    decode(8'hFF, 12'h840);
    decode(8'h33, 12'h01C);
    decode(8'hA9, 12'hFDA);
`else
    decode(8'h1B, 12'h016);
    decode(8'hFF, 12'h880);
    decode(8'h33, 12'h018);
    decode(8'hA9, 12'hFDC);
`endif
    decode(8'h80, 12'h000);
    decode(8'h05, 12'h005);

    // Backpressure: hold result 5 clocks while a second code waits.
    bus.in_valid = 1'b1;
    bus.in_fp    = 8'h1B;
    step();
    bus.in_fp    = 8'h05;
    r = 0;
    while (!bus.out_valid && r < 20) begin
      step();
      r++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", bus.out_valid, 1'b1);
`ifdef FP_DECODER_MIDPOINT_EN
      check("bp_out_data", bus.out_data, 12'h017);
`else
      check("bp_out_data", bus.out_data, 12'h016);
`endif
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    $display("backpressure held %03h for 5 clocks", bus.out_data);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp_release_idle", bus.in_ready, 1'b1);
    check("bp_release_valid", bus.out_valid, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("bp_second_accepted", bus.in_ready, 1'b0);
    step();
    check("bp_second_valid", bus.out_valid, 1'b1);
    check("bp_second_data", bus.out_data, 12'h005);
    $display("backpressure second code 05 -> %03h", bus.out_data);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Reset during the third clock of a long decode.
    bus.in_valid = 1'b1;
    bus.in_fp    = 8'hFF;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_in_ready", bus.in_ready, 1'b1);
    check("rst_mid_out_valid", bus.out_valid, 1'b0);
    check("rst_mid_out_data", bus.out_data, 12'h000);
    $display("reset mid-shift -> out_data %03h", bus.out_data);

    // Back-to-back with E=2 codes, in_valid and out_ready held high.
    b2b_code[0] = 8'h28;
    b2b_code[1] = 8'hA7;
    b2b_code[2] = 8'h2F;
`ifdef FP_DECODER_MIDPOINT_EN
    b2b_want[0] = 12'h022;
    b2b_want[1] = 12'hFE2;
    b2b_want[2] = 12'h03E;
`else
    b2b_want[0] = 12'h020;
    b2b_want[1] = 12'hFE4;
    b2b_want[2] = 12'h03C;
`endif
    k = 0;
    r = 0;
    last_t = -1;
    bus.in_valid  = 1'b1;
    bus.in_fp     = b2b_code[0];
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40 && r < 3; t++) begin
      was_ready = bus.in_ready && bus.in_valid;
      step();
      if (was_ready) begin
        k++;
        if (k < 3) begin
          bus.in_fp = b2b_code[k];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        check("b2b_data", bus.out_data, b2b_want[r]);
        if (last_t >= 0) begin
          check("b2b_period", t - last_t, 5);
        end
        $display("b2b result %0d: %03h (want %03h) at cycle %0d", r, bus.out_data, b2b_want[r], t);
        last_t = t;
        r++;
      end
    end
    check("b2b_count", r, 3);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
